// File: rtl/penalty_match_if.sv
// Purpose : bundles the referee's control inputs and its score/turn outputs.
// Latency : none, wiring only.
// Backpress: none; every signal is either a one-cycle pulse or a level.
//
// Signals (direction as seen by the referee, modport slave):
//   in : frame_tick, start, solo_enable, shot_done, goal
//   out: state[2:0], side_b_kicks, cpu_kick, kick_idx, score_a, score_b,
//        last_goal, sudden, winner[1:0], timeout
interface penalty_match_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               solo_enable;
  logic               shot_done;
  logic               goal;
  logic [2:0]         state;
  logic               side_b_kicks;
  logic               cpu_kick;
  logic [SCORE_W-1:0] kick_idx;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               last_goal;
  logic               sudden;
  logic [1:0]         winner;
  logic               timeout;

  // Game / kick logic side: drives requests and results, observes status.
  modport master (
    output frame_tick, start, solo_enable, shot_done, goal,
    input  state, side_b_kicks, cpu_kick, kick_idx, score_a, score_b,
           last_goal, sudden, winner, timeout
  );

  // Referee side.
  modport slave (
    input  frame_tick, start, solo_enable, shot_done, goal,
    output state, side_b_kicks, cpu_kick, kick_idx, score_a, score_b,
           last_goal, sudden, winner, timeout
  );
endinterface

// File: rtl/penalty_match_ctl.sv
// Purpose : penalty-shootout referee: turns, scores, kick timeout, early decision, tie handling.
// Latency : all outputs registered; shot_done -> RESULT and score update one edge later.
// Backpress: none; pulses outside their accepting state are dropped.
//
// Ports: clk, rst (sync, active-high), pm_if (penalty_match_if.slave, see interface header).
// Optional feature: define PENALTY_SUDDEN_DEATH_EN to play sudden-death pairs after a tie
// over ROUNDS pairs; otherwise such a tie ends the match as a draw (winner=3).
module penalty_match_ctl #(
  parameter int ROUNDS        = 5,
  parameter int SCORE_W       = 4,
  parameter int KICK_FRAMES   = 300,
  parameter int RESULT_FRAMES = 120
) (
  input  logic           clk,
  input  logic           rst,
  penalty_match_if.slave pm_if
);

  localparam int TMAX   = (KICK_FRAMES > RESULT_FRAMES) ? KICK_FRAMES : RESULT_FRAMES;
  localparam int KICK_W = $clog2(TMAX + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [KICK_W-1:0]  KICK_LAST  = KICK_W'(KICK_FRAMES - 1);
  localparam logic [KICK_W-1:0]  RES_LAST   = KICK_W'(RESULT_FRAMES - 1);
  localparam logic [31:0]        ROUNDS_U   = ROUNDS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_RESULT = 3'd2,
    S_OVER   = 3'd3
  } state_t;

  state_t             state_q;
  logic               side_b_q;
  logic               solo_q;
  logic               cpu_kick_q;
  logic               timeout_q;
  logic               last_goal_q;
  logic               sudden_q;
  logic [1:0]         winner_q;
  logic [SCORE_W-1:0] kick_idx_q;
  logic [SCORE_W-1:0] score_a_q;
  logic [SCORE_W-1:0] score_b_q;
  logic [KICK_W-1:0]  timer_q;

  logic               kick_expire;
  logic               result_done;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] shot_score_d;
  logic [SCORE_W-1:0] kick_idx_d;
  logic [31:0]        sa, sb, kicks_a, kicks_b, rem_a, rem_b;
  logic               lead_a, lead_b, reg_done, tied;

  always_comb begin
    kick_expire  = pm_if.frame_tick && (timer_q == KICK_LAST);
    result_done  = pm_if.frame_tick && (timer_q == RES_LAST);

    cur_score    = side_b_q ? score_b_q : score_a_q;
    shot_score_d = (pm_if.goal && (cur_score != SCORE_MAX)) ? cur_score + SCORE_W'(1) : cur_score;

    // kick_idx only advances once side B has shot; it saturates during long sudden death.
    kick_idx_d   = (side_b_q && (kick_idx_q != SCORE_MAX)) ? kick_idx_q + SCORE_W'(1) : kick_idx_q;

    // During evaluation A has always taken kick_idx+1 kicks; B has too if B just shot.
    sa      = 32'(score_a_q);
    sb      = 32'(score_b_q);
    kicks_a = 32'(kick_idx_q) + 32'd1;
    kicks_b = side_b_q ? kicks_a : 32'(kick_idx_q);
    rem_a   = (kicks_a >= ROUNDS_U) ? 32'd0 : ROUNDS_U - kicks_a;
    rem_b   = (kicks_b >= ROUNDS_U) ? 32'd0 : ROUNDS_U - kicks_b;

    // A side is out of reach when the other cannot catch up with its remaining kicks.
    lead_a   = sa > (sb + rem_b);
    lead_b   = sb > (sa + rem_a);
    reg_done = side_b_q && (kicks_a >= ROUNDS_U);
    tied     = (score_a_q == score_b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      side_b_q    <= 1'b0;
      solo_q      <= 1'b0;
      cpu_kick_q  <= 1'b0;
      timeout_q   <= 1'b0;
      last_goal_q <= 1'b0;
      sudden_q    <= 1'b0;
      winner_q    <= 2'd0;
      kick_idx_q  <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      timer_q     <= '0;
    end else begin
      cpu_kick_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (pm_if.start) begin
            state_q     <= S_AIM;
            side_b_q    <= 1'b0;
            solo_q      <= pm_if.solo_enable;
            last_goal_q <= 1'b0;
            sudden_q    <= 1'b0;
            winner_q    <= 2'd0;
            kick_idx_q  <= '0;
            score_a_q   <= '0;
            score_b_q   <= '0;
            timer_q     <= '0;
          end
        end

        S_AIM: begin
          // shot_done takes priority over an expiry landing on the same tick.
          if (pm_if.shot_done) begin
            state_q     <= S_RESULT;
            last_goal_q <= pm_if.goal;
            timer_q     <= '0;
            if (side_b_q) score_b_q <= shot_score_d;
            else          score_a_q <= shot_score_d;
          end else if (kick_expire) begin
            state_q     <= S_RESULT;
            last_goal_q <= 1'b0;
            timeout_q   <= 1'b1;
            timer_q     <= '0;
          end else if (pm_if.frame_tick) begin
            timer_q <= timer_q + KICK_W'(1);
          end
        end

        S_RESULT: begin
          if (result_done) begin
            timer_q    <= '0;
            kick_idx_q <= kick_idx_d;
            if (!sudden_q && lead_a) begin
              state_q  <= S_OVER;
              winner_q <= 2'd1;
            end else if (!sudden_q && lead_b) begin
              state_q  <= S_OVER;
              winner_q <= 2'd2;
            end else if (sudden_q && side_b_q && !tied) begin
              state_q  <= S_OVER;
              winner_q <= (score_a_q > score_b_q) ? 2'd1 : 2'd2;
            end else if (!sudden_q && reg_done) begin
              // Only reachable when tied: an unequal score with no kicks left is a lead.
`ifdef PENALTY_SUDDEN_DEATH_EN
              state_q  <= S_AIM;
              sudden_q <= 1'b1;
              side_b_q <= 1'b0;
`else
              state_q  <= S_OVER;
              winner_q <= 2'd3;
`endif
            end else begin
              state_q    <= S_AIM;
              side_b_q   <= !side_b_q;
              cpu_kick_q <= solo_q && !side_b_q;
            end
          end else if (pm_if.frame_tick) begin
            timer_q <= timer_q + KICK_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pm_if.state        = state_q;
  assign pm_if.side_b_kicks = side_b_q;
  assign pm_if.cpu_kick     = cpu_kick_q;
  assign pm_if.kick_idx     = kick_idx_q;
  assign pm_if.score_a      = score_a_q;
  assign pm_if.score_b      = score_b_q;
  assign pm_if.last_goal    = last_goal_q;
  assign pm_if.sudden       = sudden_q;
  assign pm_if.winner       = winner_q;
  assign pm_if.timeout      = timeout_q;

endmodule

// File: tb/tb_penalty_match_ctl.sv
// Purpose : directed bench for penalty_match_ctl with hand-computed expectations.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpress: n/a.
module tb_penalty_match_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  penalty_match_if #(.SCORE_W(4)) pm_if ();

  penalty_match_ctl #(
    .ROUNDS(5), .SCORE_W(4), .KICK_FRAMES(300), .RESULT_FRAMES(120)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pm_if (pm_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cpu_cnt = 0;
  int to_cnt = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (pm_if.cpu_kick === 1'b1) cpu_cnt++;
    if (pm_if.timeout === 1'b1) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic solo);
    pm_if.start       = 1'b1;
    pm_if.solo_enable = solo;
    step();
    pm_if.start       = 1'b0;
    pm_if.solo_enable = 1'b0;
  endtask

  // Hold in RESULT until evaluation, bounded.
  task automatic wait_eval();
    int n;
    n = 0;
    while (pm_if.state == 3'd2 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("result_bound", 32'(pm_if.state), 32'd1);
  endtask

  task automatic play_kick(input logic g);
    pm_if.shot_done = 1'b1;
    pm_if.goal      = g;
    step();
    pm_if.shot_done = 1'b0;
    pm_if.goal      = 1'b0;
    wait_eval();
  endtask

  initial begin
    rst               = 1'b1;
    pm_if.frame_tick  = 1'b1;
    pm_if.start       = 1'b0;
    pm_if.solo_enable = 1'b0;
    pm_if.shot_done   = 1'b0;
    pm_if.goal        = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_state",  32'(pm_if.state), 32'd0);
    check("rst_score_a", 32'(pm_if.score_a), 32'd0);
    check("rst_kick_idx", 32'(pm_if.kick_idx), 32'd0);
    check("rst_winner", 32'(pm_if.winner), 32'd0);
    check("rst_side_b", 32'(pm_if.side_b_kicks), 32'd0);
    rst = 1'b0;
    step();
    check("idle_hold", 32'(pm_if.state), 32'd0);

    // Two-player early decision: A scores 1-3, B misses 1-3
    do_start(1'b0);
    check("start_state", 32'(pm_if.state), 32'd1);
    pm_if.shot_done = 1'b1;
    pm_if.goal      = 1'b1;
    step();
    pm_if.shot_done = 1'b0;
    pm_if.goal      = 1'b0;
    check("a1_state", 32'(pm_if.state), 32'd2);
    check("a1_score_a", 32'(pm_if.score_a), 32'd1);
    check("a1_last_goal", 32'(pm_if.last_goal), 32'd1);
    // start and shot_done during RESULT are ignored
    pm_if.start     = 1'b1;
    pm_if.shot_done = 1'b1;
    pm_if.goal      = 1'b1;
    step();
    pm_if.start     = 1'b0;
    pm_if.shot_done = 1'b0;
    pm_if.goal      = 1'b0;
    check("res_ign_state", 32'(pm_if.state), 32'd2);
    check("res_ign_score_a", 32'(pm_if.score_a), 32'd1);
    check("res_ign_score_b", 32'(pm_if.score_b), 32'd0);
    wait_eval();
    check("b1_turn_state", 32'(pm_if.state), 32'd1);
    check("b1_turn_side", 32'(pm_if.side_b_kicks), 32'd1);
    play_kick(1'b0);
    check("p1_kick_idx", 32'(pm_if.kick_idx), 32'd1);
    check("p1_side", 32'(pm_if.side_b_kicks), 32'd0);
    play_kick(1'b1);
    play_kick(1'b0);
    check("p2_state", 32'(pm_if.state), 32'd1);
    play_kick(1'b1);
    play_kick(1'b0);
    check("early_state", 32'(pm_if.state), 32'd3);
    check("early_winner", 32'(pm_if.winner), 32'd1);
    check("early_kick_idx", 32'(pm_if.kick_idx), 32'd3);
    check("early_score_a", 32'(pm_if.score_a), 32'd3);
    check("two_player_cpu", 32'(cpu_cnt), 32'd0);
    // OVER is frozen
    pm_if.shot_done = 1'b1;
    pm_if.goal      = 1'b1;
    repeat (3) step();
    pm_if.shot_done = 1'b0;
    pm_if.goal      = 1'b0;
    check("over_frozen_state", 32'(pm_if.state), 32'd3);
    check("over_frozen_score", 32'(pm_if.score_a), 32'd3);

    // Restart from OVER, then reset mid-AIM with score_a=2 just before expiry
    do_start(1'b0);
    check("restart_state", 32'(pm_if.state), 32'd1);
    check("restart_score_a", 32'(pm_if.score_a), 32'd0);
    check("restart_winner", 32'(pm_if.winner), 32'd0);
    play_kick(1'b1);
    play_kick(1'b0);
    play_kick(1'b1);
    check("pre_rst_score_a", 32'(pm_if.score_a), 32'd2);
    check("pre_rst_side", 32'(pm_if.side_b_kicks), 32'd1);
    repeat (299) step();
    check("pre_rst_state", 32'(pm_if.state), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", 32'(pm_if.state), 32'd0);
    check("midrst_score_a", 32'(pm_if.score_a), 32'd0);
    check("midrst_timeout", 32'(pm_if.timeout), 32'd0);
    step();
    check("midrst_to_cnt", 32'(to_cnt), 32'd0);

    // Kick timeout and shot_done on the final tick
    do_start(1'b0);
    play_kick(1'b1);
    repeat (299) step();
    check("to_299_state", 32'(pm_if.state), 32'd1);
    check("to_299_pulse", 32'(pm_if.timeout), 32'd0);
    step();
    check("to_state", 32'(pm_if.state), 32'd2);
    check("to_pulse", 32'(pm_if.timeout), 32'd1);
    check("to_last_goal", 32'(pm_if.last_goal), 32'd0);
    check("to_score_b", 32'(pm_if.score_b), 32'd0);
    step();
    check("to_pulse_end", 32'(pm_if.timeout), 32'd0);
    wait_eval();
    check("to_kick_idx", 32'(pm_if.kick_idx), 32'd1);
    repeat (299) step();
    pm_if.shot_done = 1'b1;
    pm_if.goal      = 1'b1;
    step();
    pm_if.shot_done = 1'b0;
    pm_if.goal      = 1'b0;
    check("race_state", 32'(pm_if.state), 32'd2);
    check("race_timeout", 32'(pm_if.timeout), 32'd0);
    check("race_score_a", 32'(pm_if.score_a), 32'd2);
    check("race_last_goal", 32'(pm_if.last_goal), 32'd1);
    step();
    check("race_to_cnt", 32'(to_cnt), 32'd1);

    // Solo: CPU kick pulse when B takes over
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_start(1'b1);
    play_kick(1'b0);
    check("solo_side", 32'(pm_if.side_b_kicks), 32'd1);
    check("solo_cpu_pulse", 32'(pm_if.cpu_kick), 32'd1);
    step();
    check("solo_cpu_end", 32'(pm_if.cpu_kick), 32'd0);
    check("solo_cpu_cnt", 32'(cpu_cnt), 32'd1);

    // Tie after five pairs: 3 goals each (pairs 1-3 both score, 4-5 both miss)
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_start(1'b0);
    for (int p = 0; p < 5; p++) begin
      play_kick(p < 3);
      play_kick(p < 3);
    end
    check("tie_score_a", 32'(pm_if.score_a), 32'd3);
    check("tie_score_b", 32'(pm_if.score_b), 32'd3);
    check("tie_kick_idx", 32'(pm_if.kick_idx), 32'd5);
`ifdef PENALTY_SUDDEN_DEATH_EN
    check("sd_state", 32'(pm_if.state), 32'd1);
    check("sd_sudden", 32'(pm_if.sudden), 32'd1);
    check("sd_side", 32'(pm_if.side_b_kicks), 32'd0);
    play_kick(1'b1);
    check("sd_a_state", 32'(pm_if.state), 32'd1);
    play_kick(1'b0);
    check("sd_end_state", 32'(pm_if.state), 32'd3);
    check("sd_winner", 32'(pm_if.winner), 32'd1);
    check("sd_kick_idx", 32'(pm_if.kick_idx), 32'd6);
`else
    check("draw_state", 32'(pm_if.state), 32'd3);
    check("draw_winner", 32'(pm_if.winner), 32'd3);
    check("draw_sudden", 32'(pm_if.sudden), 32'd0);
`endif
    check("tie_cpu_cnt", 32'(cpu_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
